// File: rtl/audio_in_init_pkg.sv
// rtl/audio_in_init_pkg.sv - shared types and constants for the audio-in boot register sequencer
package audio_in_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_CHECK,
    ST_NEXT,
    ST_FAIL
  } state_t;

  localparam int ENTRY_COUNT = 4;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_WR_RESP  = 3'd1;
  localparam logic [2:0] ERR_RD_RESP  = 3'd2;
  localparam logic [2:0] ERR_MISMATCH = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Packed so element [0] is the first table entry.
  localparam logic [3:0][3:0]  TBL_OFFSET = {4'hC, 4'h8, 4'h4, 4'h0};
  localparam logic [3:0][31:0] TBL_DATA   = {32'hBEEF_0011, 32'hDEAD_0011,
                                             32'hABCD_0001, 32'h0101_FFFF};

endpackage

// File: rtl/audio_in_init_rom.sv
// rtl/audio_in_init_rom.sv - combinational index to {offset, data} lookup of the boot table
module audio_in_init_rom
  import audio_in_init_pkg::*;
(
  input  logic [1:0]  index,
  output logic [3:0]  offset,
  output logic [31:0] data
);

  always_comb begin
    offset = TBL_OFFSET[index];
    data   = TBL_DATA[index];
  end

endmodule

// File: rtl/audio_in_init_seq.sv
// rtl/audio_in_init_seq.sv - AXI4-Lite master writing the audio-in boot table; AUDIO_IN_INIT_READBACK_EN adds read-back compare
module audio_in_init_seq
  import audio_in_init_pkg::*;
#(
  parameter int          C_M_AXI_ADDR_WIDTH = 32,
  parameter int          C_M_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] C_BASE_ADDR        = 32'h0000_0000,
  parameter int          C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [2:0]                        err_code,
  output logic [1:0]                        err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  state_t                          state;
  logic [1:0]                      idx;
  logic [1:0]                      rom_idx;
  logic [3:0]                      rom_offset;
  logic [31:0]                     rom_data;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   rom_addr;
  logic                            aw_done, w_done;
  logic                            aw_hs, w_hs, aw_ok, w_ok;
  logic [31:0]                     tcnt;
  logic                            tmo;
  logic                            fail_now;
  logic [2:0]                      fail_code;

  // NEXT looks one entry ahead so the following WR can load its address and data.
  assign rom_idx  = (state == ST_IDLE) ? 2'd0 : (state == ST_NEXT) ? idx + 2'd1 : idx;
  assign rom_addr = C_M_AXI_ADDR_WIDTH'(C_BASE_ADDR) + C_M_AXI_ADDR_WIDTH'(rom_offset);

  audio_in_init_rom u_rom (
    .index  (rom_idx),
    .offset (rom_offset),
    .data   (rom_data)
  );

  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WSTRB  = '1;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID & M_AXI_WREADY;
  assign aw_ok = aw_done | aw_hs;
  assign w_ok  = w_done | w_hs;
  assign tmo   = (tcnt == 32'(C_TIMEOUT_CYCLES - 1));

`ifdef AUDIO_IN_INIT_READBACK_EN
  logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
`else
  logic unused_rd;
  assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
`endif

  always_comb begin
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    case (state)
      ST_WR: if (!(aw_ok && w_ok) && tmo) begin
        fail_now = 1'b1; fail_code = ERR_TIMEOUT;
      end
      ST_WR_RESP: if (M_AXI_BVALID) begin
        if (M_AXI_BRESP != RESP_OKAY) begin fail_now = 1'b1; fail_code = ERR_WR_RESP; end
      end else if (tmo) begin
        fail_now = 1'b1; fail_code = ERR_TIMEOUT;
      end
`ifdef AUDIO_IN_INIT_READBACK_EN
      ST_RD_ADDR: if (!M_AXI_ARREADY && tmo) begin
        fail_now = 1'b1; fail_code = ERR_TIMEOUT;
      end
      ST_RD_DATA: if (M_AXI_RVALID) begin
        if (M_AXI_RRESP != RESP_OKAY) begin fail_now = 1'b1; fail_code = ERR_RD_RESP; end
      end else if (tmo) begin
        fail_now = 1'b1; fail_code = ERR_TIMEOUT;
      end
      ST_CHECK: if (rdata_q != C_M_AXI_DATA_WIDTH'(rom_data)) begin
        fail_now = 1'b1; fail_code = ERR_MISMATCH;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      idx           <= 2'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_code      <= ERR_NONE;
      err_index     <= 2'd0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      tcnt          <= '0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
`ifdef AUDIO_IN_INIT_READBACK_EN
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rdata_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      tcnt <= tcnt + 32'd1;
      if (fail_now) begin
        state         <= ST_FAIL;
        error         <= 1'b1;
        err_code      <= fail_code;
        err_index     <= idx;
        M_AXI_AWVALID <= 1'b0;
        M_AXI_WVALID  <= 1'b0;
        M_AXI_BREADY  <= 1'b0;
`ifdef AUDIO_IN_INIT_READBACK_EN
        M_AXI_ARVALID <= 1'b0;
        M_AXI_RREADY  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            busy          <= 1'b1;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            err_index     <= 2'd0;
            idx           <= 2'd0;
            state         <= ST_WR;
            tcnt          <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            M_AXI_AWADDR  <= rom_addr;
            M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(rom_data);
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
          end
          ST_WR: begin
            if (aw_hs) M_AXI_AWVALID <= 1'b0;
            if (w_hs)  M_AXI_WVALID  <= 1'b0;
            aw_done <= aw_ok;
            w_done  <= w_ok;
            if (aw_ok && w_ok) begin
              state        <= ST_WR_RESP;
              M_AXI_BREADY <= 1'b1;
              tcnt         <= '0;
            end
          end
          ST_WR_RESP: if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            tcnt         <= '0;
`ifdef AUDIO_IN_INIT_READBACK_EN
            state         <= ST_RD_ADDR;
            M_AXI_ARADDR  <= rom_addr;
            M_AXI_ARVALID <= 1'b1;
`else
            state <= ST_NEXT;
`endif
          end
`ifdef AUDIO_IN_INIT_READBACK_EN
          ST_RD_ADDR: if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RD_DATA;
            tcnt          <= '0;
          end
          ST_RD_DATA: if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rdata_q      <= M_AXI_RDATA;
            state        <= ST_CHECK;
            tcnt         <= '0;
          end
          ST_CHECK: begin
            state <= ST_NEXT;
            tcnt  <= '0;
          end
`endif
          ST_NEXT: begin
            tcnt <= '0;
            if (idx == 2'(ENTRY_COUNT - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx           <= idx + 2'd1;
              state         <= ST_WR;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              M_AXI_AWADDR  <= rom_addr;
              M_AXI_WDATA   <= C_M_AXI_DATA_WIDTH'(rom_data);
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
            end
          end
          ST_FAIL: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_in_init_seq.sv
// tb/tb_audio_in_init_seq.sv - directed self-checking bench with a configurable AXI4-Lite slave model
module tb_audio_in_init_seq;

  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h43C0_0000;
`ifdef AUDIO_IN_INIT_READBACK_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [2:0]  err_code;
  logic [1:0]  err_index;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_fail   = 0;

  // slave knobs
  bit aw_ready_en  = 1'b1;
  int w_delay      = 0;
  bit bresp_err_en = 1'b0;
  bit rbad_en      = 1'b0;

  logic [31:0] exp_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

  always #5 clk = ~clk;

  audio_in_init_seq #(
    .C_M_AXI_ADDR_WIDTH (32),
    .C_M_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR        (BASE),
    .C_TIMEOUT_CYCLES   (TMO)
  ) dut (
    .ACLK (clk), .ARESETN (rstn), .start (start),
    .busy (busy), .done (done), .error (error), .err_code (err_code), .err_index (err_index),
    .M_AXI_AWADDR (awaddr), .M_AXI_AWPROT (awprot), .M_AXI_AWVALID (awvalid), .M_AXI_AWREADY (awready),
    .M_AXI_WDATA (wdata), .M_AXI_WSTRB (wstrb), .M_AXI_WVALID (wvalid), .M_AXI_WREADY (wready),
    .M_AXI_BRESP (bresp), .M_AXI_BVALID (bvalid), .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr), .M_AXI_ARPROT (arprot), .M_AXI_ARVALID (arvalid), .M_AXI_ARREADY (arready),
    .M_AXI_RDATA (rdata), .M_AXI_RRESP (rresp), .M_AXI_RVALID (rvalid), .M_AXI_RREADY (rready)
  );

  // ---------------- slave model ----------------
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [31:0] aw_addr_l, w_data_l;
  logic [31:0] mem [4];
  logic        bvalid_r = 1'b0, rvalid_r = 1'b0;
  logic [1:0]  bresp_r = 2'b00;
  logic [31:0] rdata_r = '0;
  int          wcnt = 0, wr_count = 0, aw_count = 0;
  logic [31:0] wlog_addr [64];
  logic [31:0] wlog_data [64];
  logic        aw_hs, w_hs, aw_have, w_have;
  logic [31:0] addr_now, data_now;

  assign awready  = aw_ready_en;
  assign wready   = (w_delay == 0) || (wcnt >= w_delay);
  assign arready  = 1'b1;
  assign bvalid   = bvalid_r;
  assign bresp    = bresp_r;
  assign rvalid   = rvalid_r;
  assign rdata    = rdata_r;
  assign rresp    = 2'b00;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign aw_have  = aw_got || aw_hs;
  assign w_have   = w_got || w_hs;
  assign addr_now = aw_hs ? awaddr : aw_addr_l;
  assign data_now = w_hs ? wdata : w_data_l;

  always @(posedge clk) begin
    if (!rstn) begin
      aw_got <= 1'b0; w_got <= 1'b0; bvalid_r <= 1'b0; bresp_r <= 2'b00;
      rvalid_r <= 1'b0; wcnt <= 0;
    end else begin
      if (aw_hs) aw_count <= aw_count + 1;
      if (aw_have && w_have && !bvalid_r) begin
        mem[addr_now[3:2]]        <= data_now;
        wlog_addr[wr_count % 64]  <= addr_now;
        wlog_data[wr_count % 64]  <= data_now;
        wr_count                  <= wr_count + 1;
        bvalid_r                  <= 1'b1;
        bresp_r                   <= (bresp_err_en && addr_now[3:2] == 2'd2) ? 2'b10 : 2'b00;
        aw_got                    <= 1'b0;
        w_got                     <= 1'b0;
      end else begin
        if (aw_hs) begin aw_got <= 1'b1; aw_addr_l <= awaddr; end
        if (w_hs)  begin w_got  <= 1'b1; w_data_l  <= wdata;  end
      end
      if (bvalid_r && bready) bvalid_r <= 1'b0;
      if (w_hs) wcnt <= 0;
      else if (aw_got || aw_hs) wcnt <= wcnt + 1;
      if (rvalid_r && rready) rvalid_r <= 1'b0;
      else if (arvalid && !rvalid_r) begin
        rvalid_r <= 1'b1;
        rdata_r  <= (rbad_en && araddr[3:2] == 2'd1) ? 32'h12345678 : mem[araddr[3:2]];
      end
    end
  end

  // WVALID/WDATA must hold while the slave stalls WREADY
  logic        prev_wpend = 1'b0;
  logic [31:0] prev_wdata = '0;
  int          viol = 0;
  always @(negedge clk) begin
    if (rstn && prev_wpend && (!wvalid || wdata != prev_wdata)) viol <= viol + 1;
    prev_wpend <= rstn && wvalid && !wready;
    prev_wdata <= wdata;
  end

  // ---------------- helpers ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_flag(input bit want_err, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!(want_err ? error : done) && cyc < 2000);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk); #1;
    n_checks++; if ({busy, done, error} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
    n_checks++; if ({err_code, err_index} !== 5'd0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", {err_code, err_index}); end
    n_checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin n_fail++; $display("FAIL reset_handshake: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    n_checks++; if ({awaddr, wdata, araddr} !== 96'd0) begin n_fail++; $display("FAIL reset_addr_data: got %h expected 0", {awaddr, wdata, araddr}); end
    n_checks++; if ({awprot, arprot, wstrb} !== 10'h00F) begin n_fail++; $display("FAIL prot_strb: got %h expected 00f", {awprot, arprot, wstrb}); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_zero_wait();
    int cyc, base;
    base = wr_count;
    pulse_start();
    n_checks++; if ({busy, awvalid, wvalid} !== 3'b111) begin n_fail++; $display("FAIL zw_issue: got %b expected 111", {busy, awvalid, wvalid}); end
    n_checks++; if (awaddr !== BASE || wdata !== 32'h0101FFFF) begin n_fail++; $display("FAIL zw_first_beat: got %h/%h expected %h/0101ffff", awaddr, wdata, BASE); end
    wait_flag(1'b0, cyc);
    n_checks++; if (cyc !== 4 * LAT) begin n_fail++; $display("FAIL zw_latency: got %0d expected %0d", cyc, 4 * LAT); end
    n_checks++; if ({busy, error} !== 2'b00) begin n_fail++; $display("FAIL zw_end_state: got %b expected 00", {busy, error}); end
    n_checks++; if (wr_count - base !== 4) begin n_fail++; $display("FAIL zw_write_count: got %0d expected 4", wr_count - base); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (wlog_addr[(base + i) % 64] !== BASE + 32'(4 * i) || wlog_data[(base + i) % 64] !== exp_data[i]) begin
        n_fail++; $display("FAIL zw_entry%0d: got %h/%h expected %h/%h", i, wlog_addr[(base + i) % 64],
                           wlog_data[(base + i) % 64], BASE + 32'(4 * i), exp_data[i]);
      end
    end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zw_done_pulse: got %b expected 0", done); end
  endtask

  task automatic test_wready_delay();
    int cyc, base;
    w_delay = 3;
    base = wr_count;
    pulse_start();
    wait_flag(1'b0, cyc);
    n_checks++; if (cyc !== 4 * (LAT + 3)) begin n_fail++; $display("FAIL wd_latency: got %0d expected %0d", cyc, 4 * (LAT + 3)); end
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL wd_wvalid_hold: got %0d drops expected 0", viol); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL wd_error: got %b expected 0", error); end
    n_checks++; if (wlog_data[(base + 1) % 64] !== 32'hABCD0001) begin n_fail++; $display("FAIL wd_data1: got %h expected abcd0001", wlog_data[(base + 1) % 64]); end
    w_delay = 0;
  endtask

  task automatic test_bresp_err();
    int cyc, aw0;
    bresp_err_en = 1'b1;
    aw0 = aw_count;
    pulse_start();
    wait_flag(1'b1, cyc);
    n_checks++; if (cyc !== 2 * LAT + 2) begin n_fail++; $display("FAIL br_latency: got %0d expected %0d", cyc, 2 * LAT + 2); end
    n_checks++; if ({err_code, err_index} !== {3'd1, 2'd2}) begin n_fail++; $display("FAIL br_code_index: got %0d/%0d expected 1/2", err_code, err_index); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL br_busy_hold: got %b expected 1", busy); end
    repeat (10) @(posedge clk); #1;
    n_checks++; if ({busy, error, done} !== 3'b010) begin n_fail++; $display("FAIL br_after: got %b expected 010", {busy, error, done}); end
    n_checks++; if (aw_count - aw0 !== 3) begin n_fail++; $display("FAIL br_no_more_aw: got %0d expected 3", aw_count - aw0); end
    bresp_err_en = 1'b0;
  endtask

`ifdef AUDIO_IN_INIT_READBACK_EN
  task automatic test_rdata_mismatch();
    int cyc;
    rbad_en = 1'b1;
    pulse_start();
    wait_flag(1'b1, cyc);
    n_checks++; if (cyc !== LAT + 5) begin n_fail++; $display("FAIL mm_latency: got %0d expected %0d", cyc, LAT + 5); end
    n_checks++; if ({err_code, err_index} !== {3'd3, 2'd1}) begin n_fail++; $display("FAIL mm_code_index: got %0d/%0d expected 3/1", err_code, err_index); end
    repeat (3) @(posedge clk);
    rbad_en = 1'b0;
  endtask
`endif

  task automatic test_timeout();
    int cyc;
    aw_ready_en = 1'b0;
    pulse_start();
    wait_flag(1'b1, cyc);
    n_checks++; if (cyc !== TMO) begin n_fail++; $display("FAIL to_latency: got %0d expected %0d", cyc, TMO); end
    n_checks++; if ({err_code, err_index} !== {3'd4, 2'd0}) begin n_fail++; $display("FAIL to_code_index: got %0d/%0d expected 4/0", err_code, err_index); end
    n_checks++; if ({awvalid, wvalid} !== 2'b00) begin n_fail++; $display("FAIL to_valid_drop: got %b expected 00", {awvalid, wvalid}); end
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_busy_fall: got %b expected 0", busy); end
    aw_ready_en = 1'b1;
    pulse_start();
    n_checks++; if ({error, err_code} !== 4'b0) begin n_fail++; $display("FAIL to_restart_clear: got %b/%0d expected 0/0", error, err_code); end
    wait_flag(1'b0, cyc);
    n_checks++; if (cyc !== 4 * LAT || error !== 1'b0) begin n_fail++; $display("FAIL to_restart_done: got %0d/%b expected %0d/0", cyc, error, 4 * LAT); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    pulse_start();
    repeat (3) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'b0) begin n_fail++; $display("FAIL rm_ctrl: got %b expected 00000000", {busy, done, error, awvalid, wvalid, bready, arvalid, rready}); end
    n_checks++; if ({awaddr, wdata, araddr, err_code, err_index} !== 101'd0) begin n_fail++; $display("FAIL rm_data: got %h expected 0", {awaddr, wdata, araddr}); end
    @(negedge clk); rstn = 1'b1;
    pulse_start();
    n_checks++; if (awaddr !== BASE || wdata !== 32'h0101FFFF) begin n_fail++; $display("FAIL rm_restart_entry0: got %h/%h expected %h/0101ffff", awaddr, wdata, BASE); end
    wait_flag(1'b0, cyc);
    n_checks++; if (cyc !== 4 * LAT || error !== 1'b0) begin n_fail++; $display("FAIL rm_restart_done: got %0d/%b expected %0d/0", cyc, error, 4 * LAT); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wready_delay();
    test_bresp_err();
`ifdef AUDIO_IN_INIT_READBACK_EN
    test_rdata_mismatch();
`endif
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_in_init_seq.md
# audio_in_init_seq

Boot-time register sequencer for the audio-in AXI4-Lite slave (S00_AXI, 4 × 32-bit registers at offsets 0x0–0xC). On a start pulse it acts as an AXI4-Lite master and writes a fixed table of configuration words. Optionally it reads each register back and compares it, then reports done or error. It sits between system reset control and the S00_AXI port, in place of the BFM master during bring-up.

## Interface
- C_M_AXI_ADDR_WIDTH, 32, address width
- C_M_AXI_DATA_WIDTH, 32, data width (only 32 supported)
- C_BASE_ADDR, 32'h0000_0000, base address of the S00_AXI slave
- C_TIMEOUT_CYCLES, 1024, maximum wait on any single channel handshake
- ACLK  in  1  clock
- ARESETN  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; ignored unless idle
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky until next accepted start; set on failure
- err_code  out  3  0 none, 1 write resp, 2 read resp, 3 data mismatch, 4 timeout
- err_index  out  2  table index of the failing entry
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master; AWPROT=ARPROT=3'b000, WSTRB=4'hF

## Operation
- Table of 4 entries: {offset, data} = {0x0,0x0101FFFF}, {0x4,0xABCD0001}, {0x8,0xDEAD0011}, {0xC,0xBEEF0011}. Address = C_BASE_ADDR + offset.
- FSM states: IDLE → WR (AW+W issued together) → WR_RESP → [RD_ADDR → RD_DATA → CHECK] → NEXT → back to WR, or DONE → IDLE. Any failure → FAIL → IDLE.
- WR: AWVALID and WVALID assert in the same cycle. Each channel deasserts independently on its own handshake. Leave the state when both have completed, including same-cycle completion.
- WR_RESP: BREADY=1. On BVALID, BRESP≠OKAY → FAIL code 1.
- RD_ADDR: ARVALID until ARREADY. RD_DATA: RREADY=1. On RVALID, RRESP≠OKAY → FAIL code 2. Otherwise latch RDATA.
- CHECK: latched data ≠ table data → FAIL code 3.
- NEXT: if index==3 → DONE, else increment index.
- Timeout counter resets on every state entry. Reaching C_TIMEOUT_CYCLES in WR, WR_RESP, RD_ADDR or RD_DATA → FAIL code 4, all VALIDs dropped.
- FAIL: error=1, err_code/err_index latched, busy drops next cycle.
- Start while busy is ignored. Start in IDLE clears error, err_code and err_index.

## Timing
- Reset values: all VALID/READY outputs 0, busy 0, done 0, error 0, err_code 0, err_index 0, addresses/data 0, FSM IDLE, index 0.
- busy rises the cycle after start. AWVALID/WVALID are asserted that same cycle.
- With zero-wait slave: 1 cycle write issue + 1 cycle B + 1 cycle AR + 1 cycle R + 1 CHECK + 1 NEXT = 6 cycles/entry. done pulses 1 cycle after the last NEXT, with busy falling the same cycle.
- VALID signals never deassert before their handshake (AXI rule), except on timeout.
- Reset mid-sequence aborts immediately. No AXI outstanding tracking is needed; the slave is reset by the same ARESETN.

## Configuration
- AUDIO_IN_INIT_READBACK_EN defined: RD_ADDR/RD_DATA/CHECK states are present, and err_code 2 and 3 are reachable.
- Not defined: WR_RESP → NEXT directly. ARVALID and RREADY are tied 0. Latency is 3 cycles/entry.

## Structure
- Package audio_in_init_pkg: FSM state enum, err_code constants, entry count (4), table offset/data constants, AXI response constants (OKAY=2'b00).
- One sub-module: audio_in_init_rom, a combinational index→{offset,data} lookup.

## Test plan
- Zero-wait slave, start → four writes with the table values to 0x0–0xC, readbacks match, done pulses, error=0.
- Slave delays WREADY 3 cycles after AWREADY → WVALID held steady, write completes, sequence proceeds normally.
- BRESP=2'b10 on entry 2 → error=1, err_code=1, err_index=2, no further AW.
- Slave returns RDATA 0x12345678 for offset 0x4 → err_code=3, err_index=1.
- AWREADY never asserted → FAIL at C_TIMEOUT_CYCLES, err_code=4, AWVALID low afterward. Then start again with a good slave → error clears, done.
- ARESETN low mid-RD_DATA → all outputs at reset values next cycle. Start after reset → full sequence from entry 0.
